// File: rtl/shift_rotate_unit_pkg.sv
// shift_rotate_unit_pkg: shared ALU types for the shift/rotate unit.
// Holds the op and size encodings, the amount width and the size-to-bits helper.
package shift_rotate_unit_pkg;

    localparam int SHIFT_AMT_W = 7;

    typedef enum logic [2:0] {
        OP_ROR, OP_ROL, OP_RCR, OP_RCL, OP_SHR, OP_SHL, OP_SAR, OP_FLIP
    } shift_op_t;

    typedef enum logic [1:0] {SZ_8, SZ_16, SZ_32, SZ_64} shift_size_t;

    function automatic logic [7:0] size_bits(shift_size_t s);
        return 8'd8 << s;
    endfunction

endpackage

// File: rtl/shift_rotate_unit_if.sv
// shift_rotate_unit_if: request/response bus of the shift/rotate unit.
// Ports: flush, in_valid/in_ready, in_op/in_size/in_carry/in_a/in_amt/in_tag,
//        out_valid/out_ready, out_result/out_carry/out_zero/out_negative/out_tag.
// master = issue stage and writeback side, slave = the unit.
interface shift_rotate_unit_if
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    shift_op_t              in_op;
    shift_size_t            in_size;
    logic                   in_carry;
    logic [WIDTH-1:0]       in_a;
    logic [SHIFT_AMT_W-1:0] in_amt;
    logic [TAG_W-1:0]       in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_result;
    logic                   out_carry;
    logic                   out_zero;
    logic                   out_negative;
    logic [TAG_W-1:0]       out_tag;

    modport master (
        output flush, in_valid, in_op, in_size, in_carry, in_a, in_amt, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_carry, out_zero, out_negative, out_tag
    );

    modport slave (
        input  flush, in_valid, in_op, in_size, in_carry, in_a, in_amt, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_carry, out_zero, out_negative, out_tag
    );
endinterface

// File: rtl/shift_rotate_unit_core.sv
// shift_rotate_core: combinational rotate/shift/bit-reverse datapath.
// Ports: op, size, carry_in, a_in, amt in; result, carry, zero, negative out.
// SHIFT_ROTATE_UNIT_FLIP_EN builds bit-reverse for op 7; otherwise op 7 passes a through.
module shift_rotate_core
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  shift_op_t              op,
    input  shift_size_t            size,
    input  logic                   carry_in,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [SHIFT_AMT_W-1:0] amt,
    output logic [WIDTH-1:0]       result,
    output logic                   carry,
    output logic                   zero,
    output logic                   negative
);
    localparam logic [7:0] WN = 8'(WIDTH);

    logic [7:0]       n, k, r, rc;
    logic [WIDTH-1:0] mask, a;
    logic [WIDTH:0]   mask1, v, vrot;
    logic             sgn;
`ifdef SHIFT_ROTATE_UNIT_FLIP_EN
    logic [WIDTH-1:0] rev;
`endif

    function automatic logic bit_at(input logic [WIDTH:0] x, input logic [7:0] i);
        logic [WIDTH:0] t;
        t = x >> i;
        return t[0];
    endfunction

    always_comb begin
        n = (size_bits(size) > WN) ? WN : size_bits(size);
        k = {1'b0, amt};
        mask = {WIDTH{1'b1}} >> (WN - n);
        mask1 = {(WIDTH+1){1'b1}} >> (WN - n);
        a = a_in & mask;
        sgn = bit_at({1'b0, a}, n - 8'd1);
        r = k & (n - 8'd1);
        rc = k % (n + 8'd1);
        // rotate-through-carry works on the (n+1)-bit value {carry_in, a}
        v = {1'b0, a} | ({{WIDTH{1'b0}}, carry_in} << n);
        vrot = '0;
`ifdef SHIFT_ROTATE_UNIT_FLIP_EN
        rev = '0;
        for (int i = 0; i < WIDTH; i++) rev[i] = a[WIDTH-1-i];
`endif
        result = a;
        carry = carry_in;
        case (op)
            OP_ROR: begin
                result = ((a >> r) | (a << (n - r))) & mask;
                carry = bit_at({1'b0, result}, n - 8'd1);
            end
            OP_ROL: begin
                result = ((a << r) | (a >> (n - r))) & mask;
                carry = result[0];
            end
            OP_RCR: begin
                vrot = ((v >> rc) | (v << (n + 8'd1 - rc))) & mask1;
                result = vrot[WIDTH-1:0] & mask;
                carry = bit_at(vrot, n);
            end
            OP_RCL: begin
                vrot = ((v << rc) | (v >> (n + 8'd1 - rc))) & mask1;
                result = vrot[WIDTH-1:0] & mask;
                carry = bit_at(vrot, n);
            end
            OP_SHR: begin
                result = (k == 8'd0) ? a : (k > n) ? '0 : a >> k;
                carry = (k == 8'd0) ? carry_in : (k > n) ? 1'b0 : bit_at({1'b0, a}, k - 8'd1);
            end
            OP_SHL: begin
                result = (k == 8'd0) ? a : (k > n) ? '0 : (a << k) & mask;
                carry = (k == 8'd0) ? carry_in : (k > n) ? 1'b0 : bit_at({1'b0, a}, n - k);
            end
            OP_SAR: begin
                result = (k == 8'd0) ? a : (k >= n) ? (sgn ? mask : '0)
                       : (a >> k) | (sgn ? mask & ~(mask >> k) : '0);
                carry = (k == 8'd0) ? carry_in : (k >= n) ? sgn : bit_at({1'b0, a}, k - 8'd1);
            end
            OP_FLIP: begin
`ifdef SHIFT_ROTATE_UNIT_FLIP_EN
                // reversing the full word puts a[n-1:0] in the top n bits
                result = rev >> (WN - n);
                carry = 1'b0;
`else
                result = a;
                carry = carry_in;
`endif
            end
            default: begin
                result = a;
                carry = carry_in;
            end
        endcase
        zero = (result == '0);
        negative = bit_at({1'b0, result}, n - 8'd1);
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// shift_rotate_unit: pipelined rotate/shift/bit-reverse unit with valid/ready handshake.
// Ports: clk, rst_n (async active-low), bus (shift_rotate_unit_if.slave).
// All compute happens before stage 0; later stages only retime. SHIFT_ROTATE_UNIT_FLIP_EN enables FLIP.
module shift_rotate_unit
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    shift_rotate_unit_if.slave bus
);
    localparam int PW = WIDTH + 3 + TAG_W;

    logic [WIDTH-1:0]  core_result;
    logic              core_carry, core_zero, core_negative;
    logic [STAGES-1:0] valid_q, valid_d, adv;
    logic [PW-1:0]     data_q [STAGES];
    logic [PW-1:0]     data_d [STAGES];
    logic [PW-1:0]     stage_in;
    logic              free, load, in_ready;

    shift_rotate_core #(.WIDTH(WIDTH)) u_core (
        .op       (bus.in_op),
        .size     (bus.in_size),
        .carry_in (bus.in_carry),
        .a_in     (bus.in_a),
        .amt      (bus.in_amt),
        .result   (core_result),
        .carry    (core_carry),
        .zero     (core_zero),
        .negative (core_negative)
    );

    always_comb begin
        // walk from the output back: a stage moves when everything after it can take data
        free = bus.out_ready;
        adv = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = valid_q[i] && free;
            free = !valid_q[i] || free;
        end
        in_ready = bus.flush || free;
        load = bus.in_valid && in_ready;
        stage_in = {core_result, core_carry, core_zero, core_negative, bus.in_tag};
        for (int i = 0; i < STAGES; i++) begin
            valid_d[i] = !bus.flush && (load || (valid_q[i] && !adv[i]));
            data_d[i] = load ? stage_in : data_q[i];
            load = adv[i];
            stage_in = data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = valid_q[STAGES-1];
    assign {bus.out_result, bus.out_carry, bus.out_zero, bus.out_negative, bus.out_tag} = data_q[STAGES-1];

endmodule

// File: tb/tb_shift_rotate_unit.sv
// tb_shift_rotate_unit: directed self-checking bench for shift_rotate_unit.
module tb_shift_rotate_unit;
    import shift_rotate_unit_pkg::*;

    localparam int WIDTH  = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [TAG_W-1:0] tag_ctr = '0;

    shift_rotate_unit_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    shift_rotate_unit #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic run(input string name, input shift_op_t op, input shift_size_t sz,
                       input logic cin, input logic [63:0] a, input logic [6:0] amt,
                       input logic [63:0] er, input logic ec, input logic ez, input logic en);
        int lat;
        tag_ctr = tag_ctr + 1'b1;
        bus.in_op = op;
        bus.in_size = sz;
        bus.in_carry = cin;
        bus.in_a = a;
        bus.in_amt = amt;
        bus.in_tag = tag_ctr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_lat"}, 64'(lat), 64'(STAGES));
        check({name, "_res"}, bus.out_result, er);
        check({name, "_c"}, 64'(bus.out_carry), 64'(ec));
        check({name, "_z"}, 64'(bus.out_zero), 64'(ez));
        check({name, "_n"}, 64'(bus.out_negative), 64'(en));
        check({name, "_tag"}, 64'(bus.out_tag), 64'(tag_ctr));
        @(negedge clk);
    endtask

    initial begin
        int sent, got, cyc;
        logic acc, stalled;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = OP_ROR;
        bus.in_size = SZ_8;
        bus.in_carry = 1'b0;
        bus.in_a = '0;
        bus.in_amt = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_result", bus.out_result, 64'd0);
        check("rst_tag", 64'(bus.out_tag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);

        run("ror1",  OP_ROR, SZ_8,  1'b0, 64'h81, 7'd1, 64'hC0, 1'b1, 1'b0, 1'b1);
        run("ror9",  OP_ROR, SZ_8,  1'b0, 64'h81, 7'd9, 64'hC0, 1'b1, 1'b0, 1'b1);
        run("rcl1",  OP_RCL, SZ_8,  1'b0, 64'h80, 7'd1, 64'h00, 1'b1, 1'b1, 1'b0);
        run("rcl9",  OP_RCL, SZ_8,  1'b0, 64'h80, 7'd9, 64'h80, 1'b0, 1'b0, 1'b1);
        run("sar40", OP_SAR, SZ_32, 1'b0, 64'h8000_0000, 7'd40, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        run("shr40", OP_SHR, SZ_32, 1'b0, 64'h8000_0000, 7'd40, 64'h0, 1'b0, 1'b1, 1'b0);
        run("shl1",  OP_SHL, SZ_16, 1'b0, 64'h8001, 7'd1, 64'h0002, 1'b1, 1'b0, 1'b0);
`ifdef SHIFT_ROTATE_UNIT_FLIP_EN
        run("flip",  OP_FLIP, SZ_16, 1'b1, 64'h0001, 7'd0, 64'h8000, 1'b0, 1'b0, 1'b1);
`else
        run("flip",  OP_FLIP, SZ_16, 1'b1, 64'h0001, 7'd0, 64'h0001, 1'b1, 1'b0, 1'b0);
`endif
        run("rol_hi", OP_ROL, SZ_8, 1'b0, 64'hFF00_0000_0000_0012, 7'd4, 64'h21, 1'b1, 1'b0, 1'b0);
        run("shr0",  OP_SHR, SZ_64, 1'b1, 64'h8000_0000_0000_0000, 7'd0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        run("shl8",  OP_SHL, SZ_8,  1'b0, 64'h01, 7'd8, 64'h0, 1'b1, 1'b1, 1'b0);
        run("rcr1",  OP_RCR, SZ_8,  1'b1, 64'h01, 7'd1, 64'h80, 1'b1, 1'b0, 1'b1);
        run("sar3",  OP_SAR, SZ_64, 1'b0, 64'hF000_0000_0000_0000, 7'd3, 64'hFE00_0000_0000_0000, 1'b0, 1'b0, 1'b1);

        // backpressure: six SHL-by-1 requests, a = 0x11*k, tag k, expect 0x22*k in order
        sent = 0;
        got = 0;
        cyc = 0;
        stalled = 1'b0;
        bus.in_op = OP_SHL;
        bus.in_size = SZ_8;
        bus.in_carry = 1'b0;
        bus.in_amt = 7'd1;
        while (got < 6 && cyc < 100) begin
            bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            bus.in_valid = (sent < 6);
            bus.in_a = 64'(17 * (sent + 1));
            bus.in_tag = TAG_W'(sent + 1);
            #1;
            if (stalled) check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            if (bus.out_valid) begin
                check("bp_tag", 64'(bus.out_tag), 64'(got + 1));
                check("bp_res", bus.out_result, 64'(34 * (got + 1)));
            end
            acc = bus.in_valid && bus.in_ready;
            stalled = bus.out_valid && !bus.out_ready;
            if (bus.out_valid && bus.out_ready) got++;
            @(negedge clk);
            if (acc) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_count", 64'(got), 64'd6);
        repeat (3) @(negedge clk);
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // flush with two requests in flight
        bus.out_ready = 1'b0;
        bus.in_op = OP_ROR;
        bus.in_a = 64'h5;
        bus.in_tag = 4'hA;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_tag = 4'hB;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        check("fl_pre_tag", 64'(bus.out_tag), 64'hA);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_tag = 4'hC;
        #1;
        check("fl_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_valid_next", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("fl_no_stale", 64'(bus.out_valid), 64'd0);
        end

        // asynchronous reset with a result waiting at the output
        bus.out_ready = 1'b0;
        bus.in_tag = 4'h9;
        bus.in_a = 64'hFF;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (STAGES - 1) @(negedge clk);
        check("rs_pre_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_out_valid", 64'(bus.out_valid), 64'd0);
        check("rs_result", bus.out_result, 64'd0);
        check("rs_tag", 64'(bus.out_tag), 64'd0);
        check("rs_carry", 64'(bus.out_carry), 64'd0);
        check("rs_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        run("post_rst", OP_ROL, SZ_16, 1'b0, 64'h8000, 7'd1, 64'h0001, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
